bcd_serial_accumulator: RTL

Multi-digit BCD accumulator that sits directly downstream of the single-digit BCD adder stage. It consumes one digit-add result (sum digit plus decimal carry) per clock and chains the carry across digits to add a DIGITS-wide packed BCD operand into a running total. A valid/ready handshake on the input and a one-cycle result strobe on the output let it sit between a digit source and a display or register stage.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_serial_accumulator.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD accumulator.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int        BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: a + b + carry-in, decimal-corrected.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [4:0] raw;

    // Binary add, then push results above nine back into the decimal range.
    always_comb begin
        raw = {1'b0, a_i} + {1'b0, b_i} + {4'd0, c_i};
        s_o = raw[3:0];
        c_o = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            s_o = raw[3:0] + BCD_CORR;
            c_o = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_accumulator.sv
// Multi-digit BCD accumulator, one digit per clock through a shared digit adder.
// Optional build macro: BCD_SAT_EN (saturate to all nines on overflow).
//
// state   | meaning
// IDLE    | waiting for an operand, in_ready high, clr honoured
// ADD     | one digit of work + operand per cycle, carry chained
// DONE    | commit work (or error) to the outputs, clr takes priority
module bcd_serial_accumulator
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [4*DIGITS-1:0]     operand_i,
    input  logic                    clr_i,
    output logic [4*DIGITS-1:0]     sum_o,
    output logic                    out_valid_o,
    output logic                    ovf_o,
    output logic                    err_o
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   carry_q;
    logic                   bad_q;
    logic [4*DIGITS-1:0]    work_q;
    logic [4*DIGITS-1:0]    opnd_q;
    logic [4*DIGITS-1:0]    sum_q;
    logic                   ovf_q;
    logic                   err_q;
    logic                   out_valid_q;
    logic                   in_ready_q;

    logic [3:0]             work_dig;
    logic [3:0]             opnd_dig;
    logic [3:0]             dig_sum_d;
    logic                   dig_carry_d;
    logic                   bad_digit_d;

    // Select the current digit pair for the shared adder.
    always_comb begin
        work_dig = work_q[idx_q*BCD_W +: BCD_W];
        opnd_dig = opnd_q[idx_q*BCD_W +: BCD_W];
    end

    // Flag an incoming operand carrying any non-decimal digit.
    always_comb begin
        bad_digit_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (operand_i[i*BCD_W +: BCD_W] > BCD_MAX) begin
                bad_digit_d = 1'b1;
            end
        end
    end

    bcd_digit_add u_digit_add (
        .a_i (work_dig),
        .b_i (opnd_dig),
        .c_i (carry_q),
        .s_o (dig_sum_d),
        .c_o (dig_carry_d)
    );

    // Sequencing FSM with registered outputs; sum only moves on commit, clr or reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            bad_q       <= 1'b0;
            work_q      <= '0;
            opnd_q      <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_i) begin
                        sum_q <= '0;
                        ovf_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                    if (in_valid_i) begin
                        opnd_q     <= operand_i;
                        // A simultaneous clr means the add starts from zero.
                        work_q     <= clr_i ? '0 : sum_q;
                        idx_q      <= '0;
                        carry_q    <= 1'b0;
                        in_ready_q <= 1'b0;
                        bad_q      <= bad_digit_d;
                        state_q    <= bad_digit_d ? ST_DONE : ST_ADD;
                    end
                end
                ST_ADD: begin
                    work_q[idx_q*BCD_W +: BCD_W] <= dig_sum_d;
                    carry_q <= dig_carry_d;
                    if (idx_q == IDX_LAST) begin
                        idx_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                    if (clr_i) begin
                        sum_q <= '0;
                        ovf_q <= 1'b0;
                        err_q <= 1'b0;
                    end else if (bad_q) begin
                        ovf_q <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
`ifdef BCD_SAT_EN
                        sum_q <= carry_q ? ALL_NINES : work_q;
`else
                        sum_q <= work_q;
`endif
                        ovf_q <= carry_q;
                        err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign sum_o       = sum_q;
    assign out_valid_o = out_valid_q;
    assign ovf_o       = ovf_q;
    assign err_o       = err_q;

`ifndef BCD_SAT_EN
    logic unused_nines;
    assign unused_nines = ^ALL_NINES;
`endif

endmodule
